// File: rtl/rv32_pkg.sv
// Shared RV32I definitions used by the write-back stage.
package rv32_pkg;

  localparam int XLEN = 32;

  // Write-back source select
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a data-memory word and extends it.
// Flags misaligned halfword/word accesses and unused load encodings.
module load_align
  import rv32_pkg::*;
#(
  parameter int XLEN = rv32_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = word[{addr_lo, 3'b000} +: 8];
  assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

  // Lane extraction and extension; unknown funct3 is an error with zero data
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        data = {{(XLEN-16){half_sel[15]}}, half_sel};
        err  = addr_lo[0];
      end
      F3_LHU: begin
        data = {{(XLEN-16){1'b0}}, half_sel};
        err  = addr_lo[0];
      end
      F3_LW: begin
        data = word;
        err  = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register: result select, register-file write port,
// WB->decode bypass and retired-instruction counter.
module wb_stage
  import rv32_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [4:0]           in_rd,
  input  logic                 in_reg_write,
  input  logic                 in_is_load,
  input  logic [1:0]           in_wb_sel,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic [XLEN-1:0]      in_alu_result,
  input  logic [XLEN-1:0]      in_mem_rdata,
  input  logic [XLEN-1:0]      in_pc_plus4,
  input  logic [XLEN-1:0]      in_imm,
  output logic                 reg_write_enable,
  output logic [4:0]           write_reg,
  output logic [XLEN-1:0]      write_back_data,
  output logic                 byp_valid,
  output logic [4:0]           byp_rd,
  output logic [XLEN-1:0]      byp_data,
  output logic                 misalign_err,
  output logic [CNT_WIDTH-1:0] instret
);

  logic                 capture;
  logic [XLEN-1:0]      ld_data;
  logic                 ld_err;
  logic                 err_d, wen_d;
  logic [XLEN-1:0]      data_d;
  logic                 wen_q, err_q;
  logic [4:0]           rd_q;
  logic [XLEN-1:0]      data_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  wb_sel_e              sel;

  // flush outranks stall; either one turns the incoming slot into a bubble
  assign capture  = in_valid && !stall && !flush;
  assign in_ready = !stall;
  assign sel      = wb_sel_e'(in_wb_sel);

  load_align #(.XLEN(XLEN)) u_align (
    .word    (in_mem_rdata),
    .funct3  (in_funct3),
    .addr_lo (in_addr_lo),
    .data    (ld_data),
    .err     (ld_err)
  );

  // Write-back source mux and write gating
  always_comb begin
    data_d = in_alu_result;
    case (sel)
      WB_ALU: data_d = in_alu_result;
      WB_MEM: data_d = ld_data;
      WB_PC4: data_d = in_pc_plus4;
      WB_IMM: data_d = in_imm;
      default: data_d = in_alu_result;
    endcase
    err_d = capture && in_is_load && ld_err;
    wen_d = capture && in_reg_write && !err_d && (in_rd != 5'd0);
  end

  // Stage register: bubbles clear the strobes but leave rd/data untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q  <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      wen_q <= wen_d;
      err_q <= err_d;
      if (capture) begin
        rd_q   <= in_rd;
        data_q <= data_d;
        cnt_q  <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign reg_write_enable = wen_q;
  assign write_reg        = rd_q;
  assign write_back_data  = data_q;
  assign byp_valid        = wen_q;
  assign byp_rd           = rd_q;
  assign byp_data         = data_q;
  assign misalign_err     = err_q;
  assign instret          = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus a randomized run
// against a behavioural model of the write-back rules.
module tb_wb_stage;

  localparam int XLEN = 32;
  localparam int CW   = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid, in_ready, stall, flush;
  logic [4:0]      in_rd;
  logic            in_reg_write, in_is_load;
  logic [1:0]      in_wb_sel;
  logic [2:0]      in_funct3;
  logic [1:0]      in_addr_lo;
  logic [31:0]     in_alu_result, in_mem_rdata, in_pc_plus4, in_imm;
  logic            reg_write_enable, byp_valid, misalign_err;
  logic [4:0]      write_reg, byp_rd;
  logic [31:0]     write_back_data, byp_data;
  logic [CW-1:0]   instret;

  int n_tot = 0;
  int n_pass = 0;

  // model state
  logic          m_wen, m_err, m_data_ok;
  logic [4:0]    m_rd;
  logic [31:0]   m_data;
  logic [CW-1:0] m_cnt;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_is_load(in_is_load), .in_wb_sel(in_wb_sel), .in_funct3(in_funct3),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result),
    .in_mem_rdata(in_mem_rdata), .in_pc_plus4(in_pc_plus4), .in_imm(in_imm),
    .reg_write_enable(reg_write_enable), .write_reg(write_reg),
    .write_back_data(write_back_data), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_data(byp_data), .misalign_err(misalign_err), .instret(instret)
  );

  // Reference load: shift-and-mask arithmetic on the word
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input int lane, output logic err);
    logic [31:0] b, h;
    err = 1'b0;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: begin err = (lane % 2) != 0; return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h; end
      3'd5: begin err = (lane % 2) != 0; return h; end
      3'd2: begin err = (lane != 0); return w; end
      default: begin err = 1'b1; return 32'h0; end
    endcase
  endfunction

  task automatic drive(input logic v, input logic st, input logic fl, input logic [4:0] rd,
                       input logic rw, input logic ld, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc4, input logic [31:0] imm);
    in_valid = v; stall = st; flush = fl; in_rd = rd; in_reg_write = rw;
    in_is_load = ld; in_wb_sel = sel; in_funct3 = f3; in_addr_lo = lo;
    in_alu_result = alu; in_mem_rdata = mem; in_pc_plus4 = pc4; in_imm = imm;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock and step the model with the inputs seen at that edge
  task automatic tick();
    logic e;
    logic [31:0] r;
    @(posedge clk);
    if (!rst_n) begin
      m_wen = 0; m_err = 0; m_rd = 0; m_data = 0; m_cnt = 0; m_data_ok = 1;
    end else if (in_valid && !stall && !flush) begin
      e = 1'b0;
      case (in_wb_sel)
        2'd0: r = in_alu_result;
        2'd1: r = ref_load(in_mem_rdata, in_funct3, int'(in_addr_lo), e);
        2'd2: r = in_pc_plus4;
        default: r = in_imm;
      endcase
      if (in_is_load)
        void'(ref_load(in_mem_rdata, in_funct3, int'(in_addr_lo), e));
      else
        e = 1'b0;
      m_err = e;
      m_wen = in_reg_write && !e && in_rd != 0;
      m_rd = in_rd;
      m_data = r;
      m_data_ok = !e;
      m_cnt = m_cnt + 1;
    end else begin
      m_wen = 0; m_err = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tot++; if ({reg_write_enable, byp_valid, misalign_err} !== 3'b000)
      $display("FAIL reset_strobes got %b want 000", {reg_write_enable, byp_valid, misalign_err});
    else n_pass++;
    n_tot++; if ({write_reg, byp_rd, write_back_data, byp_data} !== '0)
      $display("FAIL reset_data got %h/%h/%h want 0", write_reg, write_back_data, byp_data);
    else n_pass++;
    n_tot++; if (instret !== 64'd0) $display("FAIL reset_instret got %0d want 0", instret);
    else n_pass++;
    drive(1, 0, 0, 5, 1, 0, 2'd0, 0, 0, 32'h1234_5678, 0, 0, 0);
    tick();
    idle();
    n_tot++; if (reg_write_enable !== 1'b1 || write_reg !== 5'd5 || write_back_data !== 32'h1234_5678)
      $display("FAIL first_alu got we=%b rd=%0d d=%h want we=1 rd=5 d=12345678",
               reg_write_enable, write_reg, write_back_data);
    else n_pass++;
    n_tot++; if (instret !== 64'd1) $display("FAIL first_instret got %0d want 1", instret);
    else n_pass++;
    tick();
    n_tot++; if (reg_write_enable !== 1'b0 || write_reg !== 5'd5 || write_back_data !== 32'h1234_5678)
      $display("FAIL first_bubble got we=%b rd=%0d d=%h want we=0 rd=5 d=12345678",
               reg_write_enable, write_reg, write_back_data);
    else n_pass++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  los [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] exp [4] = '{32'hFFFF_FFF1, 32'h0000_0043, 32'hFFFF_8765, 32'h0000_8765};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 5'd10 + 5'(i), 1, 1, 2'd1, f3s[i], los[i], 0, 32'h8765_43F1, 0, 0);
      tick();
      n_tot++; if (write_back_data !== exp[i] || reg_write_enable !== 1'b1 || misalign_err !== 1'b0)
        $display("FAIL load_%0d got d=%h we=%b err=%b want d=%h we=1 err=0",
                 i, write_back_data, reg_write_enable, misalign_err, exp[i]);
      else n_pass++;
    end
    idle(); tick();
  endtask

  task automatic test_misalign();
    logic [CW-1:0] base;
    base = instret;
    drive(1, 0, 0, 7, 1, 1, 2'd1, 3'b010, 2'd1, 0, 32'hDEAD_BEEF, 0, 0);
    tick();
    idle();
    n_tot++; if (reg_write_enable !== 1'b0 || byp_valid !== 1'b0 || misalign_err !== 1'b1)
      $display("FAIL misalign_lw got we=%b bv=%b err=%b want 0 0 1",
               reg_write_enable, byp_valid, misalign_err);
    else n_pass++;
    n_tot++; if (instret !== base + 1) $display("FAIL misalign_instret got %0d want %0d", instret, base + 1);
    else n_pass++;
    tick();
    n_tot++; if (misalign_err !== 1'b0) $display("FAIL misalign_pulse got %b want 0", misalign_err);
    else n_pass++;
  endtask

  task automatic test_pc4();
    logic [CW-1:0] base;
    drive(1, 0, 0, 1, 1, 0, 2'd2, 0, 0, 32'hAAAA_AAAA, 0, 32'h0000_0104, 0);
    tick();
    n_tot++; if (reg_write_enable !== 1'b1 || write_reg !== 5'd1 || byp_data !== 32'h0000_0104)
      $display("FAIL pc4_rd1 got we=%b rd=%0d d=%h want 1 1 00000104",
               reg_write_enable, write_reg, byp_data);
    else n_pass++;
    base = instret;
    in_rd = 5'd0;
    tick();
    idle();
    n_tot++; if (reg_write_enable !== 1'b0 || byp_valid !== 1'b0 || instret !== base + 1)
      $display("FAIL pc4_rd0 got we=%b bv=%b ir=%0d want 0 0 %0d",
               reg_write_enable, byp_valid, instret, base + 1);
    else n_pass++;
    tick();
  endtask

  task automatic test_stall_flush();
    logic [CW-1:0] base;
    base = instret;
    drive(1, 1, 0, 9, 1, 0, 2'd0, 0, 0, 32'h5555_0000, 0, 0, 0);
    #1;
    n_tot++; if (in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", in_ready);
    else n_pass++;
    tick();
    n_tot++; if (reg_write_enable !== 1'b0) $display("FAIL stall_we got %b want 0", reg_write_enable);
    else n_pass++;
    stall = 1'b0; flush = 1'b1;
    #1;
    n_tot++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", in_ready);
    else n_pass++;
    tick();
    stall = 1'b1;  // flush+stall together
    tick();
    idle();
    n_tot++; if (reg_write_enable !== 1'b0 || instret !== base)
      $display("FAIL flush_we got we=%b ir=%0d want 0 %0d", reg_write_enable, instret, base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 5'(i), 1, 0, 2'd0, 0, 0, 32'hC000_0000 + 32'(i), 0, 0, 0);
      tick();
      n_tot++; if (reg_write_enable !== 1'b1 || byp_rd !== 5'(i) || byp_data !== 32'hC000_0000 + 32'(i))
        $display("FAIL b2b_%0d got we=%b rd=%0d d=%h want 1 %0d %h",
                 i, reg_write_enable, byp_rd, byp_data, i, 32'hC000_0000 + 32'(i));
      else n_pass++;
    end
    n_tot++; if (instret !== 64'd4) $display("FAIL b2b_instret got %0d want 4", instret);
    else n_pass++;
    tick();  // fifth op captured, still streaming
    #3 rst_n = 1'b0;
    #1;
    n_tot++; if (reg_write_enable !== 1'b0 || write_reg !== 5'd0 || write_back_data !== 32'd0 || instret !== 64'd0)
      $display("FAIL async_reset got we=%b rd=%0d d=%h ir=%0d want all 0",
               reg_write_enable, write_reg, write_back_data, instret);
    else n_pass++;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int errs = 0;
    logic [1:0] sel;
    for (int i = 0; i < 400; i++) begin
      sel = 2'($urandom_range(0, 3));
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
            5'($urandom), 1'($urandom), sel == 2'd1, sel, 3'($urandom), 2'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      if (i % 97 == 5) begin
        in_valid = 1'b1; stall = 1'b0; flush = 1'b0;
      end
      tick();
      n_tot++;
      if (reg_write_enable !== m_wen || byp_valid !== m_wen || misalign_err !== m_err ||
          write_reg !== m_rd || byp_rd !== m_rd || instret !== m_cnt ||
          in_ready !== !stall || (m_data_ok && (write_back_data !== m_data || byp_data !== m_data))) begin
        if (errs < 10)
          $display("FAIL rand_%0d got we=%b err=%b rd=%0d d=%h ir=%0d want we=%b err=%b rd=%0d d=%h ir=%0d",
                   i, reg_write_enable, misalign_err, write_reg, write_back_data, instret,
                   m_wen, m_err, m_rd, m_data, m_cnt);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    m_wen = 0; m_err = 0; m_rd = 0; m_data = 0; m_cnt = 0; m_data_ok = 1;
    test_reset();
    test_loads();
    test_misalign();
    test_pc4();
    test_stall_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
